mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 139 +++++++++++++
 tb/tb_mul_div_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers (optional MULDIV_DIV0_GUARD_EN)
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] res_hi, res_lo;
    logic [31:0] res_hi_nx, res_lo_nx;
    logic        launch, commit, move_we;
    logic        div0_block;

    // Signed ops are MULT/DIV (op[0]=0); operands are sign-extended to 64 bits
    logic        sgn;
    logic [63:0] prod;
    logic [31:0] num, den, den_safe, uq, ur, quo, rem;

    assign sgn = ~op[0];

    // Low 64 bits of a 64x64 product are the exact 32x32 result for either signedness
    assign prod = (sgn ? {{32{a[31]}}, a} : {32'd0, a})
                * (sgn ? {{32{b[31]}}, b} : {32'd0, b});

    // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend
    assign num      = (sgn && a[31]) ? (~a + 32'd1) : a;
    assign den      = (sgn && b[31]) ? (~b + 32'd1) : b;
    assign den_safe = (b == 32'd0) ? 32'd1 : den;
    assign uq       = num / den_safe;
    assign ur       = num % den_safe;
    assign quo      = (sgn && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
    assign rem      = (sgn && a[31]) ? (~ur + 32'd1) : ur;

`ifdef MULDIV_DIV0_GUARD_EN
    assign div0_block = op[1] && (b == 32'd0);
`else
    assign div0_block = 1'b0;
`endif

    // Select the result that will be latched at the launch edge
    always_comb begin
        res_hi_nx = prod[63:32];
        res_lo_nx = prod[31:0];
        if (op[1]) begin
            if (b == 32'd0) begin
                res_hi_nx = a;
                res_lo_nx = 32'hFFFF_FFFF;
            end else begin
                res_hi_nx = rem;
                res_lo_nx = quo;
            end
        end
    end

    // State and latency counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: start wins over MTHI/MTLO, both are ignored while busy
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        launch   = 1'b0;
        commit   = 1'b0;
        move_we  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!div0_block) begin
                        launch   = 1'b1;
                        cnt_nx   = op[1] ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
                        state_nx = BUSY;
                    end
                end else if (hilo_we) begin
                    move_we = 1'b1;
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    commit   = 1'b1;
                    cnt_nx   = 4'd0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result capture at launch, HI/LO update at commit or on a move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            if (launch) begin
                res_hi <= res_hi_nx;
                res_lo <= res_lo_nx;
            end
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (move_we) begin
                if (hilo_sel) hi <= a;
                else          lo <= a;
            end
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - Directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hilo_we, hilo_sel;
    logic        busy;
    logic [31:0] hi, lo;

    int vectors = 0;
    int errors  = 0;
    int n;

    mul_div_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start an op at the next edge; leaves us at the negedge after launch with operands scrambled
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Count remaining negedge samples with busy high, bounded
    task automatic count_busy(input int n0, output int cnt_out);
        cnt_out = n0;
        while (busy === 1'b1 && cnt_out < 40) begin
            cnt_out++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst_n = 1'b1;

        // MULT -1 * 2; HI/LO hold old values while busy
        launch(2'b00, 32'hFFFF_FFFF, 32'd2);
        chk("mult_hold_hi", hi, 32'd0);
        chk("mult_hold_lo", lo, 32'd0);
        count_busy(0, n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        // DIVU 100/7 with a second start on the cycle after launch
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
        chk("divu_busy_first", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        count_busy(1, n);
        chk("divu_cycles", n, 32'd10);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        @(negedge clk);
        chk("divu_no_restart", {31'd0, busy}, 32'd0);

        // DIV -7 / 2
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        count_busy(0, n);
        chk("div_cycles", n, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIV overflow case
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(0, n);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);

        // MULTU max * max
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        count_busy(0, n);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        // MTHI / MTLO in IDLE
        @(negedge clk);
        hilo_we = 1'b1; hilo_sel = 1'b1; a = 32'h1234;
        @(negedge clk);
        hilo_sel = 1'b0; a = 32'h5678;
        chk("mthi", hi, 32'h1234);
        @(negedge clk);
        hilo_we = 1'b0;
        chk("mtlo", lo, 32'h5678);
        chk("mtlo_hi_kept", hi, 32'h1234);

        // MTHI while busy is dropped
        launch(2'b00, 32'd3, 32'd4);
        hilo_we = 1'b1; hilo_sel = 1'b1; a = 32'hDEAD;
        @(negedge clk);
        hilo_we = 1'b0;
        chk("mthi_busy_ignored", hi, 32'h1234);
        count_busy(1, n);
        chk("mult2_cycles", n, 32'd5);
        chk("mult2_hi", hi, 32'd0);
        chk("mult2_lo", lo, 32'd12);

        // start and hilo_we together: start wins
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; hilo_we = 1'b1; hilo_sel = 1'b0;
        @(negedge clk);
        start = 1'b0; hilo_we = 1'b0;
        chk("prio_busy", {31'd0, busy}, 32'd1);
        chk("prio_lo_untouched", lo, 32'd12);
        count_busy(1, n);
        chk("prio_lo", lo, 32'd6);
        chk("prio_hi", hi, 32'd0);

        // Reset during a DIVU at cycle 4
        launch(2'b11, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_commit_lo", lo, 32'd0);
        chk("abort_no_commit_busy", {31'd0, busy}, 32'd0);

        // First op after reset behaves normally: 5 * -3
        launch(2'b00, 32'd5, 32'hFFFF_FFFD);
        count_busy(0, n);
        chk("post_rst_cycles", n, 32'd5);
        chk("post_rst_hi", hi, 32'hFFFF_FFFF);
        chk("post_rst_lo", lo, 32'hFFFF_FFF1);

        // Divide by zero
`ifdef MULDIV_DIV0_GUARD_EN
        launch(2'b11, 32'd5, 32'd0);
        chk("div0u_busy", {31'd0, busy}, 32'd0);
        chk("div0u_hi", hi, 32'hFFFF_FFFF);
        chk("div0u_lo", lo, 32'hFFFF_FFF1);
        launch(2'b10, 32'hFFFF_FFFB, 32'd0);
        chk("div0s_busy", {31'd0, busy}, 32'd0);
        chk("div0s_lo", lo, 32'hFFFF_FFF1);
`else
        launch(2'b11, 32'd5, 32'd0);
        count_busy(0, n);
        chk("div0u_cycles", n, 32'd10);
        chk("div0u_lo", lo, 32'hFFFF_FFFF);
        chk("div0u_hi", hi, 32'd5);
        launch(2'b10, 32'hFFFF_FFFB, 32'd0);
        count_busy(0, n);
        chk("div0s_cycles", n, 32'd10);
        chk("div0s_lo", lo, 32'hFFFF_FFFF);
        chk("div0s_hi", hi, 32'hFFFF_FFFB);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
